// File: rtl/threshold_config_pkg.sv
// rtl/threshold_config_pkg.sv - op/status codes, FSM states and reset value for threshold_config_master
package threshold_config_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_BCAST = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_BAD_CH   = 2'b01,
    ST_MISMATCH = 2'b10,
    ST_BAD_OP   = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    BCAST,
    VERIFY,
    RESP
  } state_e;

  localparam logic signed [31:0] THRESH_RESET_VALUE = 32'sd99999;

endpackage

// File: rtl/threshold_config_master_if.sv
// rtl/threshold_config_master_if.sv - host command/response channel of threshold_config_master
interface threshold_config_master_if;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_ch;
  logic signed [31:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic signed [31:0] rsp_data;
  logic [1:0]         rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_status
  );

endinterface

// File: rtl/threshold_config_master.sv
// rtl/threshold_config_master.sv - host-command sequencer for the threshold register file
// Optional write-readback checking is enabled with THRESH_CFG_VERIFY_EN.
module threshold_config_master
  import threshold_config_pkg::*;
#(
  parameter int NUM_CH       = 40,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  threshold_config_master_if.slave host,
  output logic                     busy,
  output logic                     write_threshold_value,
  output logic [7:0]               threshold_ch,
  output logic signed [31:0]       threshold_value,
  input  logic signed [31:0]       threshold_value_read
);

  localparam logic [7:0] LAST_CH  = 8'(NUM_CH - 1);
  localparam logic [7:0] LAST_LAT = 8'(READ_LATENCY);

  state_e             state;
  state_e             next_state;
  op_e                op;
  logic               bad_ch;
  logic               last_ch;
  logic               lat_done;
  logic [7:0]         lat_cnt;
  logic signed [31:0] rsp_data_q;
  status_e            rsp_status_q;
`ifdef THRESH_CFG_VERIFY_EN
  logic               bcast_q;
  logic               mismatch_q;
`endif

  assign op       = op_e'(host.cmd_op);
  assign bad_ch   = ((op == OP_WRITE) || (op == OP_READ)) && (host.cmd_ch > LAST_CH);
  assign last_ch  = (threshold_ch == LAST_CH);
  assign lat_done = (lat_cnt == LAST_LAT);

  assign host.cmd_ready      = (state == IDLE);
  assign host.rsp_valid      = (state == RESP);
  assign host.rsp_data       = rsp_data_q;
  assign host.rsp_status     = rsp_status_q;
  assign busy                = (state != IDLE);
  assign write_threshold_value = (state == WRITE) || (state == BCAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (host.cmd_valid) begin
          if (op == OP_RSVD || bad_ch) next_state = RESP;
          else if (op == OP_WRITE)     next_state = WRITE;
          else if (op == OP_READ)      next_state = READ;
          else                         next_state = BCAST;
        end
      end
`ifdef THRESH_CFG_VERIFY_EN
      WRITE:  next_state = VERIFY;
      BCAST:  next_state = VERIFY;
      VERIFY: if (lat_done) next_state = (bcast_q && !last_ch) ? BCAST : RESP;
`else
      WRITE:  next_state = RESP;
      BCAST:  if (last_ch) next_state = RESP;
`endif
      READ:   if (lat_done) next_state = RESP;
      RESP:   if (host.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Channel/value lines are registers so they hold their last driven value outside WRITE/BCAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      threshold_ch    <= '0;
      threshold_value <= '0;
      rsp_data_q      <= '0;
      rsp_status_q    <= ST_OK;
      lat_cnt         <= '0;
`ifdef THRESH_CFG_VERIFY_EN
      bcast_q         <= 1'b0;
      mismatch_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (host.cmd_valid) begin
            if (op == OP_RSVD) begin
              rsp_status_q <= ST_BAD_OP;
              rsp_data_q   <= '0;
            end else if (bad_ch) begin
              rsp_status_q <= ST_BAD_CH;
              rsp_data_q   <= '0;
            end else begin
              rsp_status_q <= ST_OK;
              rsp_data_q   <= host.cmd_data;
              threshold_ch <= (op == OP_BCAST) ? 8'd0 : host.cmd_ch;
              if (op != OP_READ) threshold_value <= host.cmd_data;
`ifdef THRESH_CFG_VERIFY_EN
              bcast_q    <= (op == OP_BCAST);
              mismatch_q <= 1'b0;
`endif
            end
          end
        end
`ifndef THRESH_CFG_VERIFY_EN
        BCAST: if (!last_ch) threshold_ch <= threshold_ch + 8'd1;
`endif
        READ: begin
          lat_cnt <= lat_cnt + 8'd1;
          if (lat_done) begin
            lat_cnt    <= '0;
            rsp_data_q <= threshold_value_read;
          end
        end
`ifdef THRESH_CFG_VERIFY_EN
        VERIFY: begin
          lat_cnt <= lat_cnt + 8'd1;
          if (lat_done) begin
            lat_cnt <= '0;
            // Only the first mismatching readback is reported.
            if (threshold_value_read != threshold_value && !mismatch_q) begin
              mismatch_q   <= 1'b1;
              rsp_data_q   <= threshold_value_read;
              rsp_status_q <= ST_MISMATCH;
            end
            if (bcast_q && !last_ch) threshold_ch <= threshold_ch + 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_config_master.sv
// tb/tb_threshold_config_master.sv - directed self-checking bench for threshold_config_master
module tb_threshold_config_master;
  import threshold_config_pkg::*;

  localparam int NUM_CH = 40;
  localparam int RL     = 1;
`ifdef THRESH_CFG_VERIFY_EN
  localparam int STEP = RL + 2;
`else
  localparam int STEP = 1;
`endif

  logic               clk;
  logic               reset;
  logic               busy;
  logic               strobe;
  logic [7:0]         th_ch;
  logic signed [31:0] th_val;
  logic signed [31:0] th_rd;
  logic               force_zero_ch7;

  int checks;
  int failures;

  threshold_config_master_if hif();

  threshold_config_master #(.NUM_CH(NUM_CH), .READ_LATENCY(RL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .host                  (hif),
    .busy                  (busy),
    .write_threshold_value (strobe),
    .threshold_ch          (th_ch),
    .threshold_value       (th_val),
    .threshold_value_read  (th_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file model: one-cycle registered readback.
  logic signed [31:0] regs [NUM_CH];
  bit                 rf_loaded;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < NUM_CH; i++) regs[i] <= THRESH_RESET_VALUE;
      rf_loaded <= 1'b1;
    end else if (strobe && th_ch < 8'(NUM_CH)) begin
      regs[th_ch] <= th_val;
    end
    if (force_zero_ch7 && th_ch == 8'd7) th_rd <= '0;
    else if (th_ch < 8'(NUM_CH))        th_rd <= regs[th_ch];
    else                                th_rd <= '0;
  end

  int                 cyc;
  int                 log_n;
  logic [7:0]         log_ch  [256];
  logic signed [31:0] log_val [256];
  int                 log_cyc [256];
  always @(negedge clk) begin
    cyc++;
    if (strobe === 1'b1) begin
      if (log_n < 256) begin
        log_ch[log_n]  = th_ch;
        log_val[log_n] = th_val;
        log_cyc[log_n] = cyc;
      end
      log_n++;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] ch, input logic signed [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    hif.cmd_op    = op;
    hif.cmd_ch    = ch;
    hif.cmd_data  = d;
    hif.cmd_valid = 1'b1;
    while (hif.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (hif.cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout cmd_ready=%b required=1", hif.cmd_ready);
    end
    @(posedge clk);
    #1 hif.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic signed [31:0] d, output logic [1:0] s, output int lat);
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (hif.rsp_valid === 1'b1) break;
    end
    if (hif.rsp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", hif.rsp_valid);
    end
    d = hif.rsp_data;
    s = hif.rsp_status;
    hif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 hif.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] ch, input logic signed [31:0] d,
                        output logic signed [31:0] rd, output logic [1:0] rs, output int lat);
    send_cmd(op, ch, d);
    wait_rsp(rd, rs, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (hif.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", hif.cmd_ready); end
    checks++; if (hif.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", hif.rsp_valid); end
    checks++; if (hif.rsp_data !== 32'sd0) begin failures++; $display("FAIL reset_rsp_data got=%0d exp=0", hif.rsp_data); end
    checks++; if (hif.rsp_status !== 2'b00) begin failures++; $display("FAIL reset_rsp_status got=%b exp=00", hif.rsp_status); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", strobe); end
    checks++; if (th_ch !== 8'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", th_ch); end
    checks++; if (th_val !== 32'sd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", th_val); end
  endtask

  task automatic test_read_after_reset();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    base = log_n;
    do_cmd(2'b01, 8'd5, 32'sd0, rd, rs, lat);
    checks++; if (rd !== 32'sd99999) begin failures++; $display("FAIL read5_data got=%0d exp=99999", rd); end
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL read5_status got=%b exp=00", rs); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL read5_latency got=%0d exp=3", lat); end
    checks++; if (log_n - base !== 0) begin failures++; $display("FAIL read5_strobes got=%0d exp=0", log_n - base); end
  endtask

  task automatic test_write();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    base = log_n;
    do_cmd(2'b00, 8'd12, -32'sd250, rd, rs, lat);
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL write12_status got=%b exp=00", rs); end
    checks++; if (rd !== -32'sd250) begin failures++; $display("FAIL write12_echo got=%0d exp=-250", rd); end
    checks++; if (log_n - base !== 1) begin failures++; $display("FAIL write12_strobes got=%0d exp=1", log_n - base); end
    checks++; if (log_ch[base] !== 8'd12 || log_val[base] !== -32'sd250) begin
      failures++; $display("FAIL write12_lines got ch=%0d val=%0d exp ch=12 val=-250", log_ch[base], log_val[base]);
    end
    do_cmd(2'b01, 8'd12, 32'sd0, rd, rs, lat);
    checks++; if (rd !== -32'sd250) begin failures++; $display("FAIL read12_data got=%0d exp=-250", rd); end
  endtask

  task automatic test_bcast();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    int                 bad;
    logic [7:0]         rd_chs [3];
    base = log_n;
    do_cmd(2'b10, 8'd99, 32'sd1200, rd, rs, lat);
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL bcast_status got=%b exp=00", rs); end
    checks++; if (rd !== 32'sd1200) begin failures++; $display("FAIL bcast_echo got=%0d exp=1200", rd); end
    checks++; if (log_n - base !== NUM_CH) begin failures++; $display("FAIL bcast_strobes got=%0d exp=%0d", log_n - base, NUM_CH); end
    bad = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (bad < 0 && (log_ch[base+i] !== 8'(i) || log_val[base+i] !== 32'sd1200)) bad = i;
    checks++; if (bad >= 0) begin
      failures++; $display("FAIL bcast_sequence at %0d got ch=%0d val=%0d exp ch=%0d val=1200", bad, log_ch[base+bad], log_val[base+bad], bad);
    end
    checks++; if (log_cyc[base+NUM_CH-1] - log_cyc[base] !== (NUM_CH-1)*STEP) begin
      failures++; $display("FAIL bcast_span got=%0d exp=%0d", log_cyc[base+NUM_CH-1] - log_cyc[base], (NUM_CH-1)*STEP);
    end
    rd_chs[0] = 8'd0; rd_chs[1] = 8'd17; rd_chs[2] = 8'd39;
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b01, rd_chs[i], 32'sd0, rd, rs, lat);
      checks++; if (rd !== 32'sd1200) begin failures++; $display("FAIL bcast_read ch=%0d got=%0d exp=1200", rd_chs[i], rd); end
    end
  endtask

  task automatic test_bad();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    base = log_n;
    do_cmd(2'b00, 8'd40, 32'sd7, rd, rs, lat);
    checks++; if (rs !== 2'b01) begin failures++; $display("FAIL bad_ch_write_status got=%b exp=01", rs); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL bad_ch_latency got=%0d exp=1", lat); end
    do_cmd(2'b11, 8'd3, 32'sd7, rd, rs, lat);
    checks++; if (rs !== 2'b11) begin failures++; $display("FAIL bad_op_status got=%b exp=11", rs); end
    do_cmd(2'b01, 8'd255, 32'sd0, rd, rs, lat);
    checks++; if (rs !== 2'b01) begin failures++; $display("FAIL bad_ch_read_status got=%b exp=01", rs); end
    checks++; if (log_n - base !== 0) begin failures++; $display("FAIL bad_strobes got=%0d exp=0", log_n - base); end
    do_cmd(2'b01, 8'd0, 32'sd0, rd, rs, lat);
    checks++; if (rd !== 32'sd1200) begin failures++; $display("FAIL bad_read0 got=%0d exp=1200", rd); end
  endtask

  task automatic test_hold();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    int                 n;
    int                 unstable;
    send_cmd(2'b00, 8'd3, 32'sd77);
    n = 0;
    while (hif.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hif.cmd_op = 2'b00; hif.cmd_ch = 8'd4; hif.cmd_data = 32'sd5; hif.cmd_valid = 1'b1;
    base = log_n;
    unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (hif.rsp_valid !== 1'b1 || hif.rsp_data !== 32'sd77 || hif.rsp_status !== 2'b00 || hif.cmd_ready !== 1'b0)
        unstable++;
    end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL hold_stable unstable_cycles=%0d exp=0", unstable); end
    checks++; if (log_n - base !== 0) begin failures++; $display("FAIL hold_strobes got=%0d exp=0", log_n - base); end
    hif.rsp_ready = 1'b1;
    @(posedge clk);
    #1 hif.rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (hif.cmd_ready !== 1'b1 || hif.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release got cmd_ready=%b rsp_valid=%b exp 1 0", hif.cmd_ready, hif.rsp_valid);
    end
    @(posedge clk);
    #1 hif.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (strobe !== 1'b1 || th_ch !== 8'd4 || th_val !== 32'sd5) begin
      failures++; $display("FAIL hold_next_accept got strobe=%b ch=%0d val=%0d exp 1 4 5", strobe, th_ch, th_val);
    end
    wait_rsp(rd, rs, lat);
    checks++; if (rd !== 32'sd5 || rs !== 2'b00) begin failures++; $display("FAIL hold_next_rsp got=%0d/%b exp=5/00", rd, rs); end
  endtask

  task automatic test_forced_readback();
    logic signed [31:0] rd;
    logic [1:0]         rs;
    int                 lat;
    int                 base;
    force_zero_ch7 = 1'b1;
    base = log_n;
    do_cmd(2'b00, 8'd7, 32'sd500, rd, rs, lat);
`ifdef THRESH_CFG_VERIFY_EN
    checks++; if (rs !== 2'b10) begin failures++; $display("FAIL verify_status got=%b exp=10", rs); end
    checks++; if (rd !== 32'sd0) begin failures++; $display("FAIL verify_data got=%0d exp=0", rd); end
`else
    checks++; if (rs !== 2'b00) begin failures++; $display("FAIL noverify_status got=%b exp=00", rs); end
    checks++; if (rd !== 32'sd500) begin failures++; $display("FAIL noverify_data got=%0d exp=500", rd); end
`endif
    checks++; if (log_n - base !== 1) begin failures++; $display("FAIL forced_strobes got=%0d exp=1", log_n - base); end
    force_zero_ch7 = 1'b0;
  endtask

  task automatic test_reset_mid_bcast();
    int n;
    int base;
    int seen_rsp;
    send_cmd(2'b10, 8'd0, 32'sd333);
    n = 0;
    while (!(strobe === 1'b1 && th_ch == 8'd20) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (!(strobe === 1'b1 && th_ch == 8'd20)) begin
      failures++; $display("FAIL midreset_reach_ch20 got strobe=%b ch=%0d exp 1 20", strobe, th_ch);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (strobe !== 1'b0 || hif.cmd_ready !== 1'b1 || hif.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_state got strobe=%b cmd_ready=%b rsp_valid=%b busy=%b exp 0 1 0 0", strobe, hif.cmd_ready, hif.rsp_valid, busy);
    end
    base = log_n;
    seen_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (hif.rsp_valid !== 1'b0) seen_rsp++;
    end
    checks++; if (seen_rsp !== 0 || log_n - base !== 0) begin
      failures++; $display("FAIL midreset_quiet got rsp_cycles=%0d strobes=%0d exp 0 0", seen_rsp, log_n - base);
    end
  endtask

  initial begin
    reset          = 1'b1;
    force_zero_ch7 = 1'b0;
    hif.cmd_valid  = 1'b0;
    hif.cmd_op     = 2'b00;
    hif.cmd_ch     = 8'd0;
    hif.cmd_data   = 32'sd0;
    hif.rsp_ready  = 1'b0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_read_after_reset();
    test_write();
    test_bcast();
    test_bad();
    test_hold();
    test_forced_readback();
    test_reset_mid_bcast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t limit=500000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/threshold_config_master.md
Name: threshold_config_master

Overview:
- Initiator side of the per-channel self-trigger threshold register file (write strobe / channel / value in, registered readback out).
- Accepts host commands over valid/ready: single write, single read, broadcast write to all channels.
- Sequences the strobe, channel and value lines with correct read latency, and returns exactly one response per command.
- Sits between the slow-control register decoder and the 40-channel filter/trigger block.

Parameters:
- NUM_CH, 40, number of threshold channels; valid channel indices are 0..NUM_CH-1.
- READ_LATENCY, 1, edges between driving threshold_ch (write low) and threshold_value_read being valid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  master can accept a command
- cmd_op  in  2  00 write, 01 read, 10 broadcast write, 11 reserved
- cmd_ch  in  8  target channel (ignored for broadcast)
- cmd_data  in  32  signed threshold value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  read value, or echo of written value
- rsp_status  out  2  00 ok, 01 bad channel, 10 verify mismatch, 11 bad op
- busy  out  1  high whenever state != IDLE
- write_threshold_value  out  1  write strobe to the register file
- threshold_ch  out  8  channel select
- threshold_value  out  32  signed write data
- threshold_value_read  in  32  registered readback from the register file

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - State IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_status=0.
  - busy=0; write_threshold_value=0; threshold_ch=0; threshold_value=0.
  - Reset mid-operation abandons the command; no response is generated; the strobe is low from the next cycle.
- Handshake: cmd_ready = (state==IDLE). A command is accepted on an edge with cmd_valid & cmd_ready; cmd fields are registered at that edge.
- Response hold: rsp_valid, rsp_data and rsp_status stay stable until the edge with rsp_ready=1. The FSM returns to IDLE at that edge, so the next command is accepted one cycle later at the earliest.
- IDLE → (on accept):
  - op 11 → RESP with status 11.
  - op 00/01 with cmd_ch >= NUM_CH → RESP with status 01. No strobe, no read.
  - op 00 → WRITE.
  - op 01 → READ.
  - op 10 → BCAST.
- WRITE (1 cycle): strobe=1, threshold_ch=cmd_ch, threshold_value=cmd_data. Then RESP with rsp_data=cmd_data, status 00.
- READ:
  - Strobe=0, threshold_ch=cmd_ch for READ_LATENCY+1 cycles.
  - threshold_value_read is sampled at the last edge into rsp_data; then RESP, status 00.
  - Latency, accept edge → rsp_valid high: 1+READ_LATENCY+1 cycles (3 at default).
- BCAST:
  - Strobe=1 for NUM_CH consecutive cycles; threshold_ch = 0,1,…,NUM_CH-1; threshold_value = cmd_data throughout.
  - Counter is 8-bit; the last write is at NUM_CH-1, with no wrap.
  - Then RESP with rsp_data=cmd_data, status 00.
- Strobe rule: write_threshold_value is never high outside WRITE/BCAST. After the last write it drops in the next cycle.
- threshold_ch and threshold_value hold their last driven value in IDLE/RESP.
- Signedness: cmd_data passes unmodified; no width conversion.
- RESP: rsp_valid=1; state returns to IDLE on rsp_ready.
- Simultaneous cmd_valid while in RESP is ignored (cmd_ready=0).

Optional Feature:
- Macro THRESH_CFG_VERIFY_EN.
- Defined:
  - After WRITE, and after each BCAST channel write, the FSM enters VERIFY: strobe=0, same channel, READ_LATENCY+1 cycles, sample and compare with cmd_data.
  - Mismatch → status 10; rsp_data = first mismatching readback. BCAST continues all channels, reporting the first mismatch.
  - BCAST then takes NUM_CH*(READ_LATENCY+2) cycles.
- Undefined: no VERIFY state; write responses always status 00 (except bad channel/op).

Decomposition:
- Package threshold_config_pkg:
  - op codes OP_WRITE/OP_READ/OP_BCAST/OP_RSVD.
  - status codes ST_OK/ST_BAD_CH/ST_MISMATCH/ST_BAD_OP.
  - FSM state enum (IDLE, WRITE, READ, BCAST, VERIFY, RESP).
  - THRESH_RESET_VALUE = 99999.
- Single module, single FSM plus channel and latency counters. No sub-module is warranted.

Test Plan:
- After reset, read ch 5 → rsp_data=99999, status 00, rsp_valid 3 cycles after accept (READ_LATENCY=1).
- Write ch 12 = -250 → exactly one strobe cycle with threshold_ch=12 and value -250. Read ch 12 → -250.
- Broadcast 1200 → 40 consecutive strobes, ch 0..39. Reading ch 0, 17, 39 each returns 1200.
- Write ch 40, and op 11 → status 01 and 11 respectively; zero strobe cycles; the register file is unchanged (read ch 0 returns previous value).
- Hold rsp_ready=0 for 10 cycles with cmd_valid=1 → rsp fields stable, cmd_ready=0, no new strobe. Then rsp_ready=1 → IDLE, next command accepted on the following edge.
- Assert reset at broadcast channel 20 → strobe low next cycle, no response, cmd_ready=1. With THRESH_CFG_VERIFY_EN and readback forced to 0 on ch 7, writing 500 to ch 7 → status 10, rsp_data=0.
